// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between an
// instruction-fetch requester (IF) and a data-access requester (MEM).
// One transaction is in flight at a time: grant -> RAM strobe -> response,
// with a one-cycle ready pulse back to the winning requester.
// MEM normally wins ties. IF is forced to win once it has watched
// STARVE_MAX MEM grants go by while it was waiting.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_ce,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ready,
  // data-access port
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  // RAM port (ram_rdata valid the cycle after a read strobe)
  output logic        ram_ce,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  // pipeline stall request
  output logic        stall_req
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_IF  = 3'd1,
    ACC_MEM = 3'd2,
    RSP_IF  = 3'd3,
    RSP_MEM = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             mem_ready_q, mem_ready_d;

  logic starve_at_max;
  logic grant_mem;
  logic grant_if;

  // Only the word index within a 4 KiB window is used; byte offset and
  // upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:12], if_addr[1:0],
                              mem_addr[31:12], mem_addr[1:0]};

  // Arbitration decision, meaningful only while in IDLE
  always_comb begin
    starve_at_max = (starve_cnt_q == CNT_MAX);
    grant_mem     = mem_ce && !(if_ce && starve_at_max);
    grant_if      = if_ce && !grant_mem;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = ACC_MEM;
          addr_d  = mem_addr[11:2];
          we_d    = mem_we;
          wdata_d = mem_wdata;
          if (if_ce && !starve_at_max) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d      = ACC_IF;
          addr_d       = if_addr[11:2];
          we_d         = 1'b0;
          starve_cnt_d = '0;
        end
      end
      ACC_IF:  state_d = RSP_IF;
      ACC_MEM: state_d = RSP_MEM;
      RSP_IF: begin
        if_data_d  = ram_rdata;
        if_ready_d = 1'b1;
        state_d    = IDLE;
      end
      RSP_MEM: begin
        if (!we_q) begin
          mem_rdata_d = ram_rdata;
        end
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM strobes are decoded from state so an async reset drops them at once
  always_comb begin
    ram_ce    = (state_q == ACC_IF) || (state_q == ACC_MEM);
    ram_we    = (state_q == ACC_MEM) && we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

  // Requester-facing outputs
  always_comb begin
    if_data   = if_data_q;
    if_ready  = if_ready_q;
    mem_rdata = mem_rdata_q;
    mem_ready = mem_ready_q;
    stall_req = (if_ce & ~if_ready_q) | (mem_ce & ~mem_ready_q);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences
// (tie-break, starvation, async reset) and a randomized run checked against
// a transaction-level model of the arbiter and RAM.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce, mem_ce, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_data, mem_rdata, ram_wdata;
  logic [31:0] ram_rdata;
  logic        if_ready, mem_ready, ram_ce, ram_we, stall_req;
  logic [9:0]  ram_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_ce(if_ce), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_req(stall_req)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h3401_1100;
    if (i == 1) return 32'hAABB_0001;
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  // Synchronous RAM model: read data appears the cycle after the strobe
  logic [31:0] ram [1024];
  logic        ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (ram_ce) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_ra;
    logic [31:0] exp_if;
    logic [31:0] exp_mr;
  } vec_t;

  vec_t vecs [8];

  // Issue one request from IDLE (call just after a negedge) and check the
  // strobe cycle, the response cycle and the ready pulse cycle.
  task automatic run_txn(input bit is_if, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [9:0] exp_ra,
                         input string tag);
    if (is_if) begin
      if_ce = 1'b1; if_addr = addr;
    end else begin
      mem_ce = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end
    #1 chk({tag, " stall at request"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    chk({tag, " ram_ce strobe"}, 32'(ram_ce), 32'd1);
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_ra));
    chk({tag, " ram_we strobe"}, 32'(ram_we), is_if ? 32'd0 : 32'(we));
    if (!is_if && we) chk({tag, " ram_wdata"}, ram_wdata, wdata);
    chk({tag, " stall acc"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    chk({tag, " ram_ce after strobe"}, 32'(ram_ce), 32'd0);
    chk({tag, " ram_we after strobe"}, 32'(ram_we), 32'd0);
    chk({tag, " early ready"}, 32'({if_ready, mem_ready}), 32'd0);
    chk({tag, " stall rsp"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    chk({tag, " if_ready"}, 32'(if_ready), 32'(is_if));
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(!is_if));
    chk({tag, " stall in ready cycle"}, 32'(stall_req), 32'd0);
    if_ce = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
  endtask

  task automatic do_reset(input bit load);
    rst = 1'b1;
    ram_load = load;
    @(posedge clk);
    #1 ram_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Randomized run state / reference model
  logic [31:0] shadow [1024];
  bit          ip, mp, mwe, exp_mem, seen, got_if, saw_ready;
  logic [31:0] ia, ma, mwd, exp_if, exp_mr;
  logic [9:0]  wa;
  int          starve, mem_grants;

  initial begin
    rst = 1'b1; ram_load = 1'b0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         10'd0,    32'h3401_1100, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_1100, 10'd0,    32'h3401_1100, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         10'd0,    32'h3401_1100, 32'h0000_1100};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         10'd1,    32'hAABB_0001, 32'h0000_1100};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         10'd1,    32'hAABB_0001, 32'hAABB_0001};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 10'd1023, 32'hAABB_0001, 32'hAABB_0001};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         10'd1023, 32'hDEAD_BEEF, 32'hAABB_0001};
    vecs[7] = '{1'b0, 1'b0, 32'hFFFF_F000, 32'h0,         10'd0,    32'hDEAD_BEEF, 32'h0000_1100};

    // Reset values
    #2;
    chk("reset ram_ce", 32'(ram_ce), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset readies", 32'({if_ready, mem_ready}), 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    chk("reset stall_req", 32'(stall_req), 32'd0);
    do_reset(1'b1);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].is_if, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_ra,
              $sformatf("vec%0d", v));
      chk($sformatf("vec%0d if_data", v), if_data, vecs[v].exp_if);
      chk($sformatf("vec%0d mem_rdata", v), mem_rdata, vecs[v].exp_mr);
      @(negedge clk);
      chk($sformatf("vec%0d ready pulse width", v), 32'({if_ready, mem_ready}), 32'd0);
      chk($sformatf("vec%0d if_data hold", v), if_data, vecs[v].exp_if);
    end

    // Simultaneous requests: MEM first, then IF
    if_ce = 1'b1; if_addr = 32'h4;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h8;
    repeat (3) @(negedge clk);
    chk("tie mem_ready first", 32'(mem_ready), 32'd1);
    chk("tie if_ready not first", 32'(if_ready), 32'd0);
    chk("tie mem_rdata", mem_rdata, init_word(2));
    mem_ce = 1'b0;
    repeat (3) @(negedge clk);
    chk("tie if_ready second", 32'(if_ready), 32'd1);
    chk("tie if_data", if_data, 32'hAABB_0001);
    if_ce = 1'b0;
    @(negedge clk);

    // Starvation: IF held, MEM re-requests after each completion
    do_reset(1'b0);
    if_ce = 1'b1; if_addr = 32'h0;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h8;
    mem_grants = 0; got_if = 1'b0;
    for (int k = 0; k < 8 && !got_if; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge clk);
        if (mem_ready) begin seen = 1'b1; mem_grants++; end
        if (if_ready)  begin seen = 1'b1; got_if = 1'b1; end
      end
      chk($sformatf("starve round %0d completion seen", k), 32'(seen), 32'd1);
      if (!seen) break;
    end
    chk("starve mem grants before IF", 32'(mem_grants), 32'(SMAX));
    chk("starve IF granted", 32'(got_if), 32'd1);
    chk("starve counter cleared", 32'(dut.starve_cnt_q), 32'd0);
    if_ce = 1'b0; mem_ce = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a store strobe
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h0000_0055;
    @(posedge clk);
    #2 chk("arst store strobe live", 32'(ram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst ram_ce", 32'(ram_ce), 32'd0);
    chk("arst ram_we", 32'(ram_we), 32'd0);
    chk("arst readies", 32'({if_ready, mem_ready}), 32'd0);
    chk("arst if_data", if_data, 32'd0);
    chk("arst mem_rdata", mem_rdata, 32'd0);
    mem_ce = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready) saw_ready = 1'b1;
    end
    chk("arst no mem_ready", 32'(saw_ready), 32'd0);
    chk("arst store aborted", ram[4], init_word(4));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 10'd4, "post-reset first grant");
    chk("post-reset if_data", if_data, init_word(4));
    @(negedge clk);

    // Randomized run against a transaction-level model
    do_reset(1'b1);
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    starve = 0; ip = 1'b0; mp = 1'b0;
    exp_if = 32'h0; exp_mr = 32'h0;
    ia = '0; ma = '0; mwd = '0; mwe = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (!ip && !mp) begin
        if ($urandom_range(1, 0) == 1) ip = 1'b1;
        else                           mp = 1'b1;
        if (ip) ia = $urandom;
        if (mp) begin ma = $urandom; mwd = $urandom; mwe = 1'($urandom_range(1, 0)); end
      end
      if_ce = ip; if_addr = ia;
      mem_ce = mp; mem_we = mwe; mem_addr = ma; mem_wdata = mwd;

      exp_mem = mp && !(ip && starve == int'(SMAX));
      wa = exp_mem ? ma[11:2] : ia[11:2];

      @(negedge clk);
      chk($sformatf("rnd%0d ram_ce", n), 32'(ram_ce), 32'd1);
      chk($sformatf("rnd%0d ram_addr", n), 32'(ram_addr), 32'(wa));
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rnd%0d mem_ready", n), 32'(mem_ready), 32'(exp_mem));
      chk($sformatf("rnd%0d if_ready", n), 32'(if_ready), 32'(!exp_mem));

      if (exp_mem) begin
        if (ip && starve < int'(SMAX)) starve++;
        if (mwe) shadow[wa] = mwd;
        else     exp_mr = shadow[wa];
      end else begin
        starve = 0;
        exp_if = shadow[wa];
      end
      chk($sformatf("rnd%0d if_data", n), if_data, exp_if);
      chk($sformatf("rnd%0d mem_rdata", n), mem_rdata, exp_mr);

      if (exp_mem) begin
        mp = ($urandom_range(3, 0) != 0);
        if (mp) begin ma = $urandom; mwd = $urandom; mwe = 1'($urandom_range(1, 0)); end
        if (!ip) begin
          ip = ($urandom_range(2, 0) == 0);
          if (ip) ia = $urandom;
        end
      end else begin
        ip = ($urandom_range(2, 0) == 0);
        if (ip) ia = $urandom;
        if (!mp) begin
          mp = ($urandom_range(1, 0) == 1);
          if (mp) begin ma = $urandom; mwd = $urandom; mwe = 1'($urandom_range(1, 0)); end
        end
      end
    end
    if_ce = 1'b0; mem_ce = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_MAX, default 4, the number of consecutive MEM grants allowed while IF waits before IF is forced to win.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: if_ce  in  1  instruction-fetch request; held high until if_ready.
REQ-005 SHALL have port: if_addr  in  32  fetch byte address.
REQ-006 SHALL have port: if_data  out  32  fetched instruction, registered.
REQ-007 SHALL have port: if_ready  out  1  one-cycle completion pulse for IF.
REQ-008 SHALL have port: mem_ce  in  1  data-access request; held high until mem_ready.
REQ-009 SHALL have port: mem_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have ports: mem_addr  in  32  data byte address; mem_wdata  in  32  store data.
REQ-011 SHALL have ports: mem_rdata  out  32  load data, registered; mem_ready  out  1  one-cycle completion pulse for MEM.
REQ-012 SHALL have ports: ram_ce  out  1; ram_we  out  1; ram_addr  out  10  word index; ram_wdata  out  32; ram_rdata  in  32, valid on the cycle after a read strobe.
REQ-013 SHALL have port: stall_req  out  1  pipeline stall request.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACC_IF, ACC_MEM, RSP_IF and RSP_MEM.
REQ-015 In IDLE, the FSM SHALL grant MEM when mem_ce=1, unless if_ce=1 and starve_cnt==STARVE_MAX, in which case it SHALL grant IF.
REQ-016 In IDLE, the FSM SHALL grant IF when if_ce=1 and mem_ce=0; with no request it SHALL stay in IDLE.
REQ-017 On a grant, the block SHALL latch the address (and mem_we and mem_wdata for MEM) and move to ACC_IF or ACC_MEM.
REQ-018 In ACC_x, the block SHALL drive ram_ce=1, ram_addr = latched addr[11:2], and for MEM ram_we = latched we and ram_wdata = latched wdata; it SHALL then move to RSP_x.
REQ-019 Outside ACC_x, the block SHALL drive ram_ce=0 and ram_we=0.
REQ-020 In RSP_IF, the block SHALL register ram_rdata into if_data, pulse if_ready=1 on the following cycle, and return to IDLE.
REQ-021 In RSP_MEM on a load, the block SHALL register ram_rdata into mem_rdata; in RSP_MEM on a store, mem_rdata SHALL remain unchanged; either way it SHALL pulse mem_ready and return to IDLE.
REQ-022 Latency SHALL be exactly 3 cycles from the grant edge to the ready pulse, and the next grant SHALL be possible in the cycle the ready pulse is high.
REQ-023 if_data and mem_rdata SHALL hold their values until the next completion of the same type.
REQ-024 starve_cnt SHALL increment on each MEM grant made while if_ce=1, saturate at STARVE_MAX, and clear on any IF grant.
REQ-025 Address bits [1:0] and [31:12] SHALL be ignored; the address space SHALL wrap modulo 1024 words.
REQ-026 stall_req SHALL equal (if_ce & ~if_ready) | (mem_ce & ~mem_ready), combinationally.
REQ-027 If a requester drops ce mid-transaction, the transaction SHALL still complete, its ready pulse SHALL still be issued, and a store SHALL not be aborted.
REQ-028 New requests arriving in non-IDLE states SHALL wait for IDLE and SHALL not be queued.

Reset
REQ-029 On rst=1, the block SHALL immediately, without waiting for clk, force state=IDLE; ram_ce=0; ram_we=0; if_ready=0; mem_ready=0; if_data=0; mem_rdata=0; starve_cnt=0; latched addr/we/wdata=0.
REQ-030 A reset during ACC_MEM with a store SHALL deassert ram_we asynchronously, and no ready pulse SHALL follow.
REQ-031 After rst falls, the first grant SHALL occur on the first clk edge with a request present.

Verification
REQ-032 IF-only fetch: RAM word 0 = 0x34011100, if_ce=1, if_addr=0x0 -> ram_ce high one cycle with ram_addr=0, if_ready pulses 3 cycles after grant, if_data=0x34011100, stall_req high until the if_ready cycle.
REQ-033 Store then load: mem_ce=1, mem_we=1, mem_addr=0x0, wdata=0x00001100, then a load from 0x0 -> ram_we high exactly one cycle, second mem_ready gives mem_rdata=0x00001100, and the store's mem_rdata is unchanged.
REQ-034 Simultaneous requests: if_ce=mem_ce=1 from IDLE, IF addr 0x4 -> MEM served first, then IF, if_data = RAM word 1.
REQ-035 Starvation: if_ce held high and mem_ce re-asserted after every mem_ready -> exactly 4 MEM grants, then 1 IF grant, with starve_cnt back to 0.
REQ-036 Address wrap: if_addr=0x00001004 -> ram_addr=1; a misaligned mem_addr=0x7 -> ram_addr=1.
REQ-037 Async reset: rst asserted mid-cycle during ACC_MEM (store) -> ram_ce/ram_we low before the next edge, no mem_ready, and all outputs at reset values.
